// File: rtl/result_pack_fifo.sv
// Packs per-lane array results into BUS_WIDTH words and buffers them in a
// show-ahead FIFO with valid/accept handshake, partial-word flush, occupancy
// count and a sticky drop flag.
module result_pack_fifo #(
  parameter  int ARRAY_WIDTH = 4,
  parameter  int DATA_WIDTH  = 16,
  parameter  int BUS_WIDTH   = 256,
  parameter  int FIFO_DEPTH  = 16,
  localparam int SLOTS       = BUS_WIDTH / DATA_WIDTH,
  localparam int AW          = $clog2(FIFO_DEPTH),
  localparam int FW          = $clog2(SLOTS)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  array_reset_n [ARRAY_WIDTH],
  input  logic [DATA_WIDTH-1:0] array_results [ARRAY_WIDTH],
  input  logic                  flush_i,
  output logic [BUS_WIDTH-1:0]  data_o,
  output logic [SLOTS-1:0]      keep_o,
  output logic                  valid_o,
  input  logic                  accepted_i,
  output logic                  stall_o,
  output logic [AW:0]           count_o,
  output logic                  overflow_o
);

  typedef struct packed {
    logic [BUS_WIDTH-1:0] data;
    logic [SLOTS-1:0]     keep;
  } entry_t;

  // pack state
  logic [BUS_WIDTH-1:0]  pack_q, pack_n, pack_ins;
  logic [FW-1:0]         fill_q, fill_n;
  logic [FW:0]           fill_inc;
  logic                  pend_q, pend_n;
  logic                  ovf_q, ovf_set;

  // lane select
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;

  // fifo
  entry_t                mem [FIFO_DEPTH];
  entry_t                push_entry, head;
  logic [AW:0]           wr_ptr, rd_ptr;
  logic                  full, empty, push, pop, push_ok;
  logic                  complete, flush_req;
  logic [SLOTS-1:0]      keep_part;

  // lowest-index low lane wins; scanning downward lets it overwrite the rest
  always_comb begin
    in_valid = 1'b0;
    in_data  = '0;
    for (int i = ARRAY_WIDTH - 1; i >= 0; i--) begin
      if (!array_reset_n[i]) begin
        in_valid = 1'b1;
        in_data  = array_results[i];
      end
    end
  end

  assign fill_inc = (FW+1)'(fill_q) + (FW+1)'(in_valid);

  // current word with this cycle's element dropped into slot fill, plus the
  // keep mask a partial push would carry
  always_comb begin
    pack_ins  = pack_q;
    keep_part = '0;
    for (int k = 0; k < SLOTS; k++) begin
      if (in_valid && fill_q == FW'(k))
        pack_ins[k*DATA_WIDTH +: DATA_WIDTH] = in_data;
      keep_part[k] = ((FW+1)'(k) < fill_inc);
    end
  end

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign pop       = accepted_i && !empty;
  assign push_ok   = !full || pop;
  assign complete  = in_valid && (fill_q == FW'(SLOTS - 1));
  assign flush_req = pend_q || (flush_i && (fill_q != '0 || in_valid));

  // pack/flush control: a completed word always wins over a pending flush;
  // a dropped completing element leaves the word untouched
  always_comb begin
    push            = 1'b0;
    push_entry.data = pack_ins;
    push_entry.keep = keep_part;
    pack_n          = pack_q;
    fill_n          = fill_q;
    pend_n          = pend_q;
    ovf_set         = 1'b0;
    if (complete) begin
      if (push_ok) begin
        push            = 1'b1;
        push_entry.keep = '1;
        pack_n          = '0;
        fill_n          = '0;
        pend_n          = 1'b0;
      end else begin
        ovf_set = 1'b1;
        pend_n  = flush_req;
      end
    end else if (flush_req && push_ok) begin
      push   = 1'b1;
      pack_n = '0;
      fill_n = '0;
      pend_n = 1'b0;
    end else begin
      pack_n = pack_ins;
      fill_n = fill_inc[FW-1:0];
      pend_n = flush_req;
    end
  end

  // pack register, fill counter, pending flush and sticky overflow
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pack_q <= '0;
      fill_q <= '0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      pack_q <= pack_n;
      fill_q <= fill_n;
      pend_q <= pend_n;
      if (ovf_set) ovf_q <= 1'b1;
    end
  end

  // fifo pointers, wrapping through the extra MSB
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // storage needs no reset: outputs are masked while empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_entry;
  end

  assign head       = mem[rd_ptr[AW-1:0]];
  assign valid_o    = !empty;
  assign data_o     = valid_o ? head.data : '0;
  assign keep_o     = valid_o ? head.keep : '0;
  assign stall_o    = full;
  assign count_o    = wr_ptr - rd_ptr;
  assign overflow_o = ovf_q;

endmodule
